// File: rtl/input_channel_dequeue_scheduler_if.sv
// Bundles the signals between the trigger stage, the pipeline control
// and the input channel buffers around input_channel_dequeue_scheduler.
// master: the environment side (trigger stage, pipeline control, buffers).
// slave : the scheduler.
interface input_channel_dequeue_scheduler_if #(
  parameter int NUM_INPUT_CHANNELS = 4,
  parameter int COUNT_WIDTH        = 3
);
  logic [NUM_INPUT_CHANNELS-1:0][COUNT_WIDTH-1:0] input_channel_counts;
  logic                                           trigger_valid;
  logic [NUM_INPUT_CHANNELS-1:0]                  trigger_icd;
  logic                                           stall;
  logic                                           flush;
  logic [NUM_INPUT_CHANNELS-1:0]                  dequeue;
  logic [NUM_INPUT_CHANNELS-1:0]                  updated_input_channel_empty_status;
  logic                                           dequeue_underflow_error;

  modport master (
    output input_channel_counts, trigger_valid, trigger_icd, stall, flush,
    input  dequeue, updated_input_channel_empty_status, dequeue_underflow_error
  );

  modport slave (
    input  input_channel_counts, trigger_valid, trigger_icd, stall, flush,
    output dequeue, updated_input_channel_empty_status, dequeue_underflow_error
  );
endinterface

// File: rtl/input_channel_dequeue_scheduler.sv
// input_channel_dequeue_scheduler
// Tracks input-channel dequeues that were triggered but not yet performed.
// A triggered instruction's ICD vector travels through DEQUEUE_STAGES
// stall-aware stages; the last stage drives the dequeue pulses. Per-channel
// pending counters subtract in-flight dequeues from the raw buffer counts so
// the trigger stage never sees a channel head that is already claimed.
// Optional feature: define TIA_DEQUEUE_UNDERFLOW_CHECK_EN to build the sticky
// underflow detector; otherwise dequeue_underflow_error is tied low.
module input_channel_dequeue_scheduler #(
  parameter int NUM_INPUT_CHANNELS = 4,
  parameter int COUNT_WIDTH        = 3,
  parameter int DEQUEUE_STAGES     = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input_channel_dequeue_scheduler_if.slave bus
);
  localparam int N  = NUM_INPUT_CHANNELS;
  localparam int D  = DEQUEUE_STAGES;
  localparam int PW = $clog2(D + 1);
  localparam int EW = (COUNT_WIDTH > PW) ? COUNT_WIDTH : PW;

  logic [N-1:0]  r_stage [D];
  logic [PW-1:0] r_pending [N];
  logic [PW-1:0] w_pending_nxt [N];
  logic [N-1:0]  w_enter;
  logic [N-1:0]  w_exit;
  logic [N-1:0]  w_empty;
  logic          w_advance;

  // Occupancy minus in-flight dequeues, clamped at zero instead of wrapping.
  function automatic logic [EW-1:0] sat_sub(input logic [EW-1:0] a,
                                            input logic [EW-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  // Entry/exit vectors, counter updates and corrected empty flags.
  always_comb begin
    w_advance = ~bus.stall & ~bus.flush;
    w_enter   = bus.trigger_valid ? bus.trigger_icd : '0;
    w_exit    = r_stage[D-1];
    w_empty   = '0;
    for (int i = 0; i < N; i++) begin
      w_pending_nxt[i] = r_pending[i];
      case ({w_enter[i], w_exit[i]})
        2'b10:   w_pending_nxt[i] = r_pending[i] + PW'(1);
        2'b01:   w_pending_nxt[i] = r_pending[i] - PW'(1);
        default: w_pending_nxt[i] = r_pending[i];
      endcase
      // The exiting entry still counts: the buffer decrements only after it.
      w_empty[i] = (sat_sub(EW'(bus.input_channel_counts[i]),
                            EW'(r_pending[i])) == '0);
    end
  end

  // Shift pipeline and pending counters: flush clears, stall holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < D; k++) r_stage[k] <= '0;
      for (int i = 0; i < N; i++) r_pending[i] <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < D; k++) r_stage[k] <= '0;
      for (int i = 0; i < N; i++) r_pending[i] <= '0;
    end else if (w_advance) begin
      r_stage[0] <= w_enter;
      for (int k = 1; k < D; k++) r_stage[k] <= r_stage[k-1];
      for (int i = 0; i < N; i++) r_pending[i] <= w_pending_nxt[i];
    end
  end

  // A stalled exit stage must not pulse; it pulses once the stall lifts.
  assign bus.dequeue = r_stage[D-1] & {N{~bus.stall}};
  assign bus.updated_input_channel_empty_status = w_empty;

`ifdef TIA_DEQUEUE_UNDERFLOW_CHECK_EN
  logic r_underflow;

  // Sticky flag: an accepted trigger consumed a channel that looked empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
    end else if (w_advance && bus.trigger_valid && |(bus.trigger_icd & w_empty)) begin
      r_underflow <= 1'b1;
    end
  end

  assign bus.dequeue_underflow_error = r_underflow;
`else
  assign bus.dequeue_underflow_error = 1'b0;
`endif
endmodule

// File: tb/tb_input_channel_dequeue_scheduler.sv
// Testbench for input_channel_dequeue_scheduler (N=4, COUNT_WIDTH=3, D=2).
// A queue of in-flight instructions with ages predicts dequeue, empty status
// and the underflow flag every cycle; directed scenarios add literal checks.
module tb_input_channel_dequeue_scheduler;
  localparam int N = 4;
  localparam int D = 2;
`ifdef TIA_DEQUEUE_UNDERFLOW_CHECK_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  input_channel_dequeue_scheduler_if #(.NUM_INPUT_CHANNELS(4), .COUNT_WIDTH(3)) bus ();

  input_channel_dequeue_scheduler #(
    .NUM_INPUT_CHANNELS(4), .COUNT_WIDTH(3), .DEQUEUE_STAGES(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each in-flight instruction: its ICD vector and how many advances it has
  // seen since acceptance (1 = just accepted). It dequeues at age D.
  logic [N-1:0] m_icd[$];
  int           m_age[$];
  bit           m_err = 1'b0;

  function automatic int m_pend(input int ch);
    int c = 0;
    foreach (m_icd[j]) if (m_icd[j][ch]) c++;
    return c;
  endfunction

  function automatic logic [N-1:0] m_empty();
    logic [N-1:0] e;
    for (int ch = 0; ch < N; ch++)
      e[ch] = (int'(bus.input_channel_counts[ch]) <= m_pend(ch));
    return e;
  endfunction

  function automatic logic [N-1:0] m_deq();
    logic [N-1:0] d = '0;
    foreach (m_age[j]) if (m_age[j] == D) d |= m_icd[j];
    if (bus.stall) d = '0;
    return d;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_icd.delete(); m_age.delete(); m_err = 1'b0;
    end else if (bus.flush) begin
      m_icd.delete(); m_age.delete();
    end else if (!bus.stall) begin
      if (UF_EN && bus.trigger_valid && |(bus.trigger_icd & m_empty())) m_err = 1'b1;
      for (int j = 0; j < m_age.size(); j++) m_age[j]++;
      while (m_age.size() > 0 && m_age[0] > D) begin
        void'(m_age.pop_front());
        void'(m_icd.pop_front());
      end
      if (bus.trigger_valid) begin
        m_icd.push_back(bus.trigger_icd);
        m_age.push_back(1);
      end
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      chk4("cyc_dequeue", bus.dequeue, m_deq());
      chk4("cyc_empty", bus.updated_input_channel_empty_status, m_empty());
      chk1("cyc_error", bus.dequeue_underflow_error, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic drive(input logic tv, input logic [3:0] icd, input logic st, input logic fl);
    bus.trigger_valid = tv;
    bus.trigger_icd   = icd;
    bus.stall         = st;
    bus.flush         = fl;
  endtask

  task automatic set_cnt(input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] c3);
    bus.input_channel_counts[0] = c0;
    bus.input_channel_counts[1] = c1;
    bus.input_channel_counts[2] = c2;
    bus.input_channel_counts[3] = c3;
  endtask

  initial begin
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    set_cnt(3'd0, 3'd0, 3'd0, 3'd0);
    run_cmp = 1'b1;

    // Reset state
    smp();
    chk4("rst_dequeue", bus.dequeue, 4'b0000);
    chk4("rst_empty", bus.updated_input_channel_empty_status, 4'b1111);
    chk1("rst_error", bus.dequeue_underflow_error, 1'b0);
    nxt(); reset_n = 1'b1;
    smp(); nxt();

    // Single dequeue on channel 0
    set_cnt(3'd1, 3'd0, 3'd0, 3'd0); drive(1'b1, 4'b0001, 1'b0, 1'b0);
    smp(); chk4("single_t_empty", bus.updated_input_channel_empty_status, 4'b1110);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0);
    smp(); chk4("single_t1_empty", bus.updated_input_channel_empty_status, 4'b1111);
           chk4("single_t1_deq", bus.dequeue, 4'b0000);
    nxt();
    smp(); chk4("single_t2_deq", bus.dequeue, 4'b0001);
           chk4("single_t2_empty", bus.updated_input_channel_empty_status, 4'b1111);
    nxt(); set_cnt(3'd0, 3'd0, 3'd0, 3'd0);
    smp(); chk4("single_t3_deq", bus.dequeue, 4'b0000);
           chk4("single_t3_empty", bus.updated_input_channel_empty_status, 4'b1111);
    nxt();

    // Back-to-back on channel 1
    set_cnt(3'd0, 3'd2, 3'd0, 3'd0); drive(1'b1, 4'b0010, 1'b0, 1'b0);
    smp(); chk4("b2b_t_empty", bus.updated_input_channel_empty_status, 4'b1101);
    nxt(); drive(1'b1, 4'b0010, 1'b0, 1'b0);
    smp(); chk4("b2b_t1_empty", bus.updated_input_channel_empty_status, 4'b1101);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0);
    smp(); chk4("b2b_t2_empty", bus.updated_input_channel_empty_status, 4'b1111);
           chk4("b2b_t2_deq", bus.dequeue, 4'b0010);
    nxt(); set_cnt(3'd0, 3'd1, 3'd0, 3'd0);
    smp(); chk4("b2b_t3_deq", bus.dequeue, 4'b0010);
    nxt(); set_cnt(3'd0, 3'd0, 3'd0, 3'd0);
    smp(); chk4("b2b_t4_deq", bus.dequeue, 4'b0000);
           chk1("b2b_no_error", bus.dequeue_underflow_error, 1'b0);
    nxt();

    // Stall: two stalled cycles push the pulse from t+2 to t+4
    set_cnt(3'd1, 3'd0, 3'd0, 3'd0); drive(1'b1, 4'b0001, 1'b0, 1'b0);
    smp();
    nxt(); drive(1'b1, 4'b0001, 1'b1, 1'b0);
    smp(); chk4("stall_t1_deq", bus.dequeue, 4'b0000);
    nxt(); drive(1'b1, 4'b0001, 1'b1, 1'b0);
    smp(); chk4("stall_t2_deq", bus.dequeue, 4'b0000);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0);
    smp(); chk4("stall_t3_deq", bus.dequeue, 4'b0000);
    nxt();
    smp(); chk4("stall_t4_deq", bus.dequeue, 4'b0001);
    nxt(); set_cnt(3'd0, 3'd0, 3'd0, 3'd0);
    smp(); chk4("stall_t5_deq", bus.dequeue, 4'b0000);
           chk1("stall_trigger_ignored", bus.dequeue_underflow_error, 1'b0);
    nxt();

    // Flush with two in-flight entries on channel 2
    set_cnt(3'd0, 3'd0, 3'd2, 3'd0); drive(1'b1, 4'b0100, 1'b0, 1'b0);
    smp();
    nxt(); drive(1'b1, 4'b0100, 1'b0, 1'b0);
    smp();
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b1);
    smp(); chk4("flush_exit_deq", bus.dequeue, 4'b0100);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0); set_cnt(3'd0, 3'd0, 3'd1, 3'd0);
    smp(); chk4("flush_pending_cleared", bus.updated_input_channel_empty_status, 4'b1011);
           chk4("flush_t1_deq", bus.dequeue, 4'b0000);
    nxt();
    smp(); chk4("flush_t2_deq", bus.dequeue, 4'b0000);
    nxt(); set_cnt(3'd0, 3'd0, 3'd0, 3'd0);

    // Underflow on empty channel 3
    drive(1'b1, 4'b1000, 1'b0, 1'b0);
    smp(); chk1("uf_t_error", bus.dequeue_underflow_error, 1'b0);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0);
    smp(); chk1("uf_t1_error", bus.dequeue_underflow_error, UF_EN);
    nxt(); smp();
    nxt(); smp(); chk1("uf_held", bus.dequeue_underflow_error, UF_EN);
    nxt();
    reset_n = 1'b0;
    #1;
    chk1("uf_cleared_by_reset", bus.dequeue_underflow_error, 1'b0);
    chk4("rst2_empty", bus.updated_input_channel_empty_status, 4'b1111);
    nxt(); reset_n = 1'b1;

    // Mid-operation reset discards an in-flight dequeue
    set_cnt(3'd1, 3'd0, 3'd0, 3'd0); drive(1'b1, 4'b0001, 1'b0, 1'b0);
    nxt(); drive(1'b0, 4'b0000, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk4("rst_mid_empty", bus.updated_input_channel_empty_status, 4'b1110);
    nxt(); reset_n = 1'b1;
    smp(); chk4("rst_mid_no_deq", bus.dequeue, 4'b0000);
    nxt();

    // Mixed traffic with stalls, flushes and arbitrary occupancies
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
      set_cnt(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      nxt();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    nxt(); smp();
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
